// File: rtl/dht11_reader_pkg.sv
// Shared types and frame layout for the DHT11 reader.
// Byte 4 is the first byte on the wire, byte 0 the checksum.
package dht11_reader_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_REL,
        S_ACK_LO,
        S_ACK_HI,
        S_BIT_LO,
        S_BIT_HI,
        S_CHECK,
        S_CONV,
        S_ERR
    } state_t;

    localparam int FRAME_BITS = 40;

    localparam int HUM_INT  = 4;
    localparam int HUM_DEC  = 3;
    localparam int TEMP_INT = 2;
    localparam int TEMP_DEC = 1;
    localparam int CSUM     = 0;

    function automatic logic [7:0] frame_byte(
        input logic [FRAME_BITS-1:0] f,
        input int                    idx
    );
        return f[idx*8 +: 8];
    endfunction

endpackage

// File: rtl/dht11_reader_bin8_to_bcd2.sv
// Sequential divide-by-10 of an 8-bit value into two BCD digits.
// Values above 99 saturate to 9,9; done pulses once per start.
module bin8_to_bcd2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       done,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic       busy;
    logic [7:0] rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            rem  <= 8'd0;
            tens <= 4'd0;
            ones <= 4'd0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy <= 1'b1;
                ones <= 4'd0;
                if (bin > 8'd99) begin
                    rem  <= 8'd9;
                    tens <= 4'd9;
                end else begin
                    rem  <= bin;
                    tens <= 4'd0;
                end
            end else if (busy) begin
                if (rem >= 8'd10) begin
                    rem  <= rem - 8'd10;
                    tens <= tens + 4'd1;
                end else begin
                    ones <= rem[3:0];
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dht11_reader.sv
// DHT11 single-wire poller: start pulse, 40-bit capture, checksum,
// and BCD conversion of integer humidity and temperature.
module dht11_reader
    import dht11_reader_pkg::*;
#(
    parameter int CLKS_PER_US   = 25,
    parameter int POLL_MS       = 2000,
    parameter int START_LOW_US  = 18000,
    parameter int TIMEOUT_US    = 200,
    parameter int BIT_THRESH_US = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dht_in,
    output logic       dht_oe,
    output logic [3:0] hum_value_10,
    output logic [3:0] hum_value_1,
    output logic [3:0] temp_value_10,
    output logic [3:0] temp_value_1,
    output logic       data_valid,
    output logic       read_error
);

    localparam int PW = $clog2(CLKS_PER_US + 1);

    localparam logic [31:0] POLL_LAST  = 32'(POLL_MS * 1000 - 1);
    localparam logic [31:0] START_LAST = 32'(START_LOW_US - 1);
    localparam logic [31:0] TO_LAST    = 32'(TIMEOUT_US - 1);
    localparam logic [31:0] THRESH     = 32'(BIT_THRESH_US);

    logic                  sync1;
    logic                  line;
    logic [PW-1:0]         pre_cnt;
    logic                  tick;
    logic                  timed_out;
    state_t                state;
    logic [31:0]           timer;
    logic [FRAME_BITS-1:0] frame;
    logic [5:0]            bit_cnt;
    logic                  conv_sel;
    logic                  bcd_start;
    logic                  bcd_done;
    logic [7:0]            bcd_bin;
    logic [3:0]            bcd_tens;
    logic [3:0]            bcd_ones;
    logic [3:0]            hum_t;
    logic [3:0]            hum_o;
    logic [7:0]            csum_calc;
    logic                  csum_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            line  <= 1'b1;
        end else begin
            sync1 <= dht_in;
            line  <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || tick) pre_cnt <= '0;
        else               pre_cnt <= pre_cnt + 1'b1;
    end

    assign tick      = (pre_cnt == PW'(CLKS_PER_US - 1));
    assign timed_out = tick && (timer == TO_LAST);

    assign csum_calc = frame_byte(frame, HUM_INT)
                     + frame_byte(frame, HUM_DEC)
                     + frame_byte(frame, TEMP_INT)
                     + frame_byte(frame, TEMP_DEC);
    assign csum_ok   = (csum_calc == frame_byte(frame, CSUM));

    assign bcd_bin = conv_sel ? frame_byte(frame, TEMP_INT)
                              : frame_byte(frame, HUM_INT);

    bin8_to_bcd2 u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (bcd_start),
        .bin   (bcd_bin),
        .done  (bcd_done),
        .tens  (bcd_tens),
        .ones  (bcd_ones)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            timer         <= '0;
            frame         <= '0;
            bit_cnt       <= '0;
            conv_sel      <= 1'b0;
            bcd_start     <= 1'b0;
            hum_t         <= '0;
            hum_o         <= '0;
            dht_oe        <= 1'b0;
            hum_value_10  <= '0;
            hum_value_1   <= '0;
            temp_value_10 <= '0;
            temp_value_1  <= '0;
            data_valid    <= 1'b0;
            read_error    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            read_error <= 1'b0;
            bcd_start  <= 1'b0;
            if (tick) timer <= timer + 32'd1;
            unique case (state)
                S_IDLE: begin
                    if (tick && timer == POLL_LAST) begin
                        state  <= S_START;
                        timer  <= '0;
                        dht_oe <= 1'b1;
                    end
                end
                S_START: begin
                    if (tick && timer == START_LAST) begin
                        state  <= S_REL;
                        timer  <= '0;
                        dht_oe <= 1'b0;
                    end
                end
                // Ignore the first 2 us: the synchronizer still holds our own pulse.
                S_REL: begin
                    if (timed_out) begin
                        state <= S_ERR;
                        timer <= '0;
                    end else if (!line && timer >= 32'd2) begin
                        state <= S_ACK_LO;
                        timer <= '0;
                    end
                end
                S_ACK_LO: begin
                    if (timed_out) begin
                        state <= S_ERR;
                        timer <= '0;
                    end else if (line) begin
                        state <= S_ACK_HI;
                        timer <= '0;
                    end
                end
                S_ACK_HI: begin
                    if (timed_out) begin
                        state <= S_ERR;
                        timer <= '0;
                    end else if (!line) begin
                        state   <= S_BIT_LO;
                        timer   <= '0;
                        bit_cnt <= '0;
                    end
                end
                S_BIT_LO: begin
                    if (timed_out) begin
                        state <= S_ERR;
                        timer <= '0;
                    end else if (line) begin
                        state <= S_BIT_HI;
                        timer <= '0;
                    end
                end
                S_BIT_HI: begin
                    if (timed_out) begin
                        state <= S_ERR;
                        timer <= '0;
                    end else if (!line) begin
                        frame   <= {frame[FRAME_BITS-2:0], (timer > THRESH)};
                        bit_cnt <= bit_cnt + 6'd1;
                        timer   <= '0;
                        if (bit_cnt == 6'(FRAME_BITS - 1)) state <= S_CHECK;
                        else                               state <= S_BIT_LO;
                    end
                end
                S_CHECK: begin
                    timer <= '0;
                    if (csum_ok) begin
                        state     <= S_CONV;
                        conv_sel  <= 1'b0;
                        bcd_start <= 1'b1;
                    end else begin
                        state <= S_ERR;
                    end
                end
                S_CONV: begin
                    if (bcd_done) begin
                        if (!conv_sel) begin
                            hum_t     <= bcd_tens;
                            hum_o     <= bcd_ones;
                            conv_sel  <= 1'b1;
                            bcd_start <= 1'b1;
                        end else begin
                            hum_value_10  <= hum_t;
                            hum_value_1   <= hum_o;
                            temp_value_10 <= bcd_tens;
                            temp_value_1  <= bcd_ones;
                            data_valid    <= 1'b1;
                            state         <= S_IDLE;
                            timer         <= '0;
                        end
                    end
                end
                S_ERR: begin
                    read_error <= 1'b1;
                    state      <= S_IDLE;
                    timer      <= '0;
                end
                default: begin
                    state  <= S_IDLE;
                    timer  <= '0;
                    dht_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dht11_reader.sv
// Bench for dht11_reader: behavioural sensor on the bus and a
// digit model computed from the frame bytes with plain arithmetic.
module tb_dht11_reader;

    localparam int CPU = 2;
    localparam int PER = 10;
    localparam int US  = CPU * PER;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       sensor = 1'b1;
    logic       dht_in;
    logic       dht_oe;
    logic [3:0] hum_value_10;
    logic [3:0] hum_value_1;
    logic [3:0] temp_value_10;
    logic [3:0] temp_value_1;
    logic       data_valid;
    logic       read_error;

    int          n_cmp   = 0;
    int          n_bad   = 0;
    int          dv_cnt  = 0;
    int          re_cnt  = 0;
    logic [15:0] exp_dig = 16'h0;

    assign dht_in = dht_oe ? 1'b0 : sensor;

    always #(PER / 2) clk = ~clk;

    dht11_reader #(
        .CLKS_PER_US   (CPU),
        .POLL_MS       (1),
        .START_LOW_US  (20),
        .TIMEOUT_US    (200),
        .BIT_THRESH_US (50)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .dht_in        (dht_in),
        .dht_oe        (dht_oe),
        .hum_value_10  (hum_value_10),
        .hum_value_1   (hum_value_1),
        .temp_value_10 (temp_value_10),
        .temp_value_1  (temp_value_1),
        .data_valid    (data_valid),
        .read_error    (read_error)
    );

    always @(posedge clk) begin
        if (data_valid) dv_cnt++;
        if (read_error) re_cnt++;
    end

    function automatic logic [15:0] digits();
        return {hum_value_10, hum_value_1, temp_value_10, temp_value_1};
    endfunction

    function automatic logic [15:0] ref_digits(input int h, input int t);
        int hs;
        int ts;
        hs = (h > 99) ? 99 : h;
        ts = (t > 99) ? 99 : t;
        return {4'(hs / 10), 4'(hs % 10), 4'(ts / 10), 4'(ts % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs,
                               input int lo, input int hi);
        n_cmp++;
        assert (obs >= lo && obs <= hi) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic wait_oe(input logic lvl, input int max,
                           output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        while (n < max) begin
            @(negedge clk);
            n++;
            if (dht_oe === lvl) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic send_frame(input logic [39:0] f, input int abort_bit,
                              output bit aborted);
        aborted = 1'b0;
        #(30 * US) sensor = 1'b0;
        #(80 * US) sensor = 1'b1;
        #(80 * US);
        for (int i = 0; i < 40; i++) begin
            sensor = 1'b0;
            if (i == abort_bit) begin
                #(10 * US);
                @(negedge clk) reset = 1'b1;
                @(posedge clk);
                #1;
                check("rst_mid_oe", 32'(dht_oe), 32'd0);
                check("rst_mid_digits", 32'(digits()), 32'd0);
                exp_dig = 16'h0;
                @(negedge clk) reset = 1'b0;
                sensor  = 1'b1;
                aborted = 1'b1;
                return;
            end
            #(30 * US) sensor = 1'b1;
            #((f[39-i] ? 70 : 26) * US);
        end
        sensor = 1'b0;
        #(40 * US) sensor = 1'b1;
    endtask

    task automatic run_txn(input logic [7:0] h, input logic [7:0] hd,
                           input logic [7:0] t, input logic [7:0] td,
                           input logic [7:0] cs, input int abort_bit,
                           input bit need_start, input string tag);
        int   n;
        bit   ok;
        bit   ab;
        int   dv0;
        int   re0;
        logic exp_ok;
        if (need_start) begin
            wait_oe(1'b1, 2100, n, ok);
            check({tag, "_start"}, 32'(ok), 32'd1);
        end
        wait_oe(1'b0, 60, n, ok);
        check_range({tag, "_start_len"}, n, 39, 41);
        dv0 = dv_cnt;
        re0 = re_cnt;
        send_frame({h, hd, t, td, cs}, abort_bit, ab);
        if (!ab) begin
            repeat (100) @(negedge clk);
            exp_ok = (8'(h + hd + t + td) == cs);
            if (exp_ok) exp_dig = ref_digits(int'(h), int'(t));
            check({tag, "_dv"}, 32'(dv_cnt - dv0), 32'(exp_ok));
            check({tag, "_err"}, 32'(re_cnt - re0), 32'(!exp_ok));
            check({tag, "_digits"}, 32'(digits()), 32'(exp_dig));
            check({tag, "_oe"}, 32'(dht_oe), 32'd0);
        end else begin
            check({tag, "_pulses"}, 32'(dv_cnt - dv0 + re_cnt - re0), 32'd0);
        end
    endtask

    initial begin
        int          n;
        bit          ok;
        logic [7:0]  rh;
        logic [7:0]  rhd;
        logic [7:0]  rt;
        logic [7:0]  rtd;
        logic [7:0]  rcs;

        repeat (5) @(negedge clk);
        check("rst_oe", 32'(dht_oe), 32'd0);
        check("rst_digits", 32'(digits()), 32'd0);
        check("rst_dv", 32'(data_valid), 32'd0);
        check("rst_err", 32'(read_error), 32'd0);
        reset = 1'b0;

        wait_oe(1'b1, 2100, n, ok);
        check_range("first_start", n, 1999, 2001);
        run_txn(8'h37, 8'h00, 8'h18, 8'h00, 8'h4F, -1, 1'b0, "valid");
        check("valid_fixed", 32'(digits()), 32'h5524);

        run_txn(8'h37, 8'h00, 8'h18, 8'h00, 8'h50, -1, 1'b1, "badsum");

        wait_oe(1'b1, 2100, n, ok);
        check("silent_start", 32'(ok), 32'd1);
        wait_oe(1'b0, 60, n, ok);
        check("silent_release", 32'(ok), 32'd1);
        n = 0;
        while (n < 600 && read_error !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        check_range("silent_err_lat", n, 399, 403);
        check("silent_oe", 32'(dht_oe), 32'd0);
        check("silent_digits", 32'(digits()), 32'(exp_dig));
        wait_oe(1'b1, 2100, n, ok);
        check_range("silent_repoll", n, 1997, 2001);

        run_txn(8'h64, 8'h00, 8'h18, 8'h00, 8'h7C, -1, 1'b0, "hum100");
        run_txn(8'h2A, 8'h00, 8'h11, 8'h00, 8'h3B, 17, 1'b1, "rst_mid");
        run_txn(8'h2A, 8'h03, 8'h11, 8'h05, 8'h43, -1, 1'b1, "post_rst");

        for (int k = 0; k < 3; k++) begin
            rh  = 8'($urandom_range(0, 140));
            rhd = 8'($urandom_range(0, 9));
            rt  = 8'($urandom_range(0, 60));
            rtd = 8'($urandom_range(0, 9));
            rcs = rh + rhd + rt + rtd;
            if ($urandom_range(0, 3) == 0) rcs = rcs + 8'd1;
            run_txn(rh, rhd, rt, rtd, rcs, -1, 1'b1, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
